map_rom_arbiter: RTL and testbench

MAP_ROM_ARBITER -- requirements
Module: map_rom_arbiter

---
 rtl/map_rom_arbiter.sv | 133 +++++++++++++
 tb/tb_map_rom_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/map_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : map_rom_arbiter
// Function : Shares one combinational map ROM between a real-time overlay
//            reader and a tracer reader with a starvation-forced tracer grant.
// Revision : 1.0 - initial release
// ============================================================================
module map_rom_arbiter #(
  parameter int MAP_WIDTH_BITS  = 4,
  parameter int MAP_HEIGHT_BITS = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ov_req,
  input  logic [MAP_WIDTH_BITS-1:0]  ov_col,
  input  logic [MAP_HEIGHT_BITS-1:0] ov_row,
  output logic                       ov_val,
  output logic                       ov_valid,
  output logic                       ov_stale,
  input  logic                       tr_req,
  input  logic [MAP_WIDTH_BITS-1:0]  tr_col,
  input  logic [MAP_HEIGHT_BITS-1:0] tr_row,
  output logic                       tr_ack,
  output logic                       tr_val,
  output logic [MAP_WIDTH_BITS-1:0]  rom_col,
  output logic [MAP_HEIGHT_BITS-1:0] rom_row,
  input  logic                       rom_val
);

  typedef enum logic [1:0] {
    GNT_NONE      = 2'd0,
    GNT_OV        = 2'd1,
    GNT_TR        = 2'd2,
    GNT_TR_FORCED = 2'd3
  } grant_t;

  localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);

  grant_t     grant;
  logic       tr_eff;
  logic       tr_win;
  logic       ov_val_q,   ov_val_d;
  logic       ov_valid_q, ov_valid_d;
  logic       ov_stale_q, ov_stale_d;
  logic       tr_val_q,   tr_val_d;
  logic       tr_ack_q,   tr_ack_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  // A tracer request seen in its own ack cycle is the tail of the old one.
  always_comb begin
    grant  = GNT_NONE;
    tr_eff = tr_req & ~tr_ack_q;
    if (!reset) begin
      if (ov_req && tr_eff) begin
        grant = (starve_cnt_q >= STARVE_LIMIT_C) ? GNT_TR_FORCED : GNT_OV;
      end else if (ov_req) begin
        grant = GNT_OV;
      end else if (tr_eff) begin
        grant = GNT_TR;
      end
    end
  end

  assign tr_win = (grant == GNT_TR) || (grant == GNT_TR_FORCED);

  always_comb begin
    rom_col = '0;
    rom_row = '0;
    if (grant == GNT_OV) begin
      rom_col = ov_col;
      rom_row = ov_row;
    end else if (tr_win) begin
      rom_col = tr_col;
      rom_row = tr_row;
    end
  end

  always_comb begin
    ov_val_d     = ov_val_q;
    ov_valid_d   = 1'b0;
    ov_stale_d   = 1'b0;
    tr_val_d     = tr_val_q;
    tr_ack_d     = 1'b0;
    starve_cnt_d = starve_cnt_q;
    if (grant == GNT_OV) begin
      ov_val_d   = rom_val;
      ov_valid_d = 1'b1;
    end
    if (tr_win) begin
      tr_val_d = rom_val;
      tr_ack_d = 1'b1;
    end
    // Overlay cannot stall, so a forced tracer grant still answers it, flagged stale.
    if (grant == GNT_TR_FORCED) begin
      ov_valid_d = ov_req;
      ov_stale_d = ov_req;
    end
    if (!tr_eff || tr_win) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != 4'hF) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ov_val_q     <= 1'b0;
      ov_valid_q   <= 1'b0;
      ov_stale_q   <= 1'b0;
      tr_val_q     <= 1'b0;
      tr_ack_q     <= 1'b0;
      starve_cnt_q <= 4'd0;
    end else begin
      ov_val_q     <= ov_val_d;
      ov_valid_q   <= ov_valid_d;
      ov_stale_q   <= ov_stale_d;
      tr_val_q     <= tr_val_d;
      tr_ack_q     <= tr_ack_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Outputs read as zero for the whole reset cycle, including the one whose
  // registers still hold a pre-reset grant.
  assign ov_val   = ov_val_q   & ~reset;
  assign ov_valid = ov_valid_q & ~reset;
  assign ov_stale = ov_stale_q & ~reset;
  assign tr_val   = tr_val_q   & ~reset;
  assign tr_ack   = tr_ack_q   & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_map_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_rom_arbiter
// Function : Scoreboard bench for map_rom_arbiter against a reference map.
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_rom_arbiter;

  localparam int W     = 4;
  localparam int H     = 4;
  localparam int LIMIT = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         ov_req, tr_req;
  logic [W-1:0] ov_col, tr_col, rom_col;
  logic [H-1:0] ov_row, tr_row, rom_row;
  logic         ov_val, ov_valid, ov_stale, tr_ack, tr_val, rom_val;

  logic map_mem [256];
  assign rom_val = map_mem[{rom_row, rom_col}];

  always #5 clk = ~clk;

  map_rom_arbiter #(
    .MAP_WIDTH_BITS (W),
    .MAP_HEIGHT_BITS(H),
    .STARVE_LIMIT   (LIMIT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ov_req  (ov_req),
    .ov_col  (ov_col),
    .ov_row  (ov_row),
    .ov_val  (ov_val),
    .ov_valid(ov_valid),
    .ov_stale(ov_stale),
    .tr_req  (tr_req),
    .tr_col  (tr_col),
    .tr_row  (tr_row),
    .tr_ack  (tr_ack),
    .tr_val  (tr_val),
    .rom_col (rom_col),
    .rom_row (rom_row),
    .rom_val (rom_val)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic ov_valid;
    logic ov_stale;
    logic ov_val;
    logic tr_ack;
    logic tr_val;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   m_e, m_n;
  int     m_starve = 0;
  int     m_g;
  logic   m_tr_eff;
  logic [W-1:0] m_col;
  logic [H-1:0] m_row;

  // Expected outputs for the next cycle are pushed each cycle and popped one cycle later.
  always @(negedge clk) begin
    m_e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (reset) m_e = '0;
    check_val("ov_valid", 32'(ov_valid), 32'(m_e.ov_valid));
    check_val("ov_stale", 32'(ov_stale), 32'(m_e.ov_stale));
    check_val("ov_val",   32'(ov_val),   32'(m_e.ov_val));
    check_val("tr_ack",   32'(tr_ack),   32'(m_e.tr_ack));
    check_val("tr_val",   32'(tr_val),   32'(m_e.tr_val));
    m_n = m_e;
    m_n.ov_valid = 1'b0;
    m_n.ov_stale = 1'b0;
    m_n.tr_ack   = 1'b0;
    m_col = '0;
    m_row = '0;
    if (reset) begin
      m_n      = '0;
      m_starve = 0;
    end else begin
      m_tr_eff = tr_req && !m_e.tr_ack;
      if (ov_req && m_tr_eff) m_g = (m_starve >= LIMIT) ? 3 : 1;
      else if (ov_req)        m_g = 1;
      else if (m_tr_eff)      m_g = 2;
      else                    m_g = 0;
      if (m_g == 1) begin
        m_col = ov_col;
        m_row = ov_row;
        m_n.ov_valid = 1'b1;
        m_n.ov_val   = map_mem[{ov_row, ov_col}];
      end else if (m_g >= 2) begin
        m_col = tr_col;
        m_row = tr_row;
        m_n.tr_ack = 1'b1;
        m_n.tr_val = map_mem[{tr_row, tr_col}];
        m_n.ov_valid = (m_g == 3);
        m_n.ov_stale = (m_g == 3);
      end
      if (!m_tr_eff || m_g >= 2) m_starve = 0;
      else if (m_starve < 15)    m_starve++;
    end
    check_val("rom_col", 32'(rom_col), 32'(m_col));
    check_val("rom_row", 32'(rom_row), 32'(m_row));
    exp_q.push_back(m_n);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycles from the current drive point until tr_ack is seen; 99 on timeout.
  task automatic ack_latency(output int lat, output logic held_ok);
    logic last_ov;
    lat     = 99;
    held_ok = 1'b0;
    last_ov = ov_val;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #2;
      if (tr_ack) begin
        lat     = n + 1;
        held_ok = (ov_val == last_ov) && ov_valid && ov_stale;
        break;
      end
      last_ov = ov_val;
    end
  endtask

  int   lat;
  logic held_ok;

  initial begin
    for (int i = 0; i < 256; i++) map_mem[i] = 1'($urandom_range(0, 1));
    map_mem[{4'd5, 4'd3}] = 1'b1;
    map_mem[{4'd2, 4'd7}] = 1'b0;
    map_mem[{4'd4, 4'd9}] = 1'b1;
    reset  = 1'b1;
    ov_req = 1'b0; ov_col = '0; ov_row = '0;
    tr_req = 1'b0; tr_col = '0; tr_row = '0;
    step(3);
    check_val("rst_ov_valid", 32'(ov_valid), 32'd0);
    check_val("rst_rom_col",  32'(rom_col),  32'd0);
    reset = 1'b0;
    step(1);

    // Overlay only.
    ov_req = 1'b1; ov_col = 4'd3; ov_row = 4'd5;
    step(1);
    ov_req = 1'b0;
    #1;
    check_val("ov_only_valid", 32'(ov_valid), 32'd1);
    check_val("ov_only_val",   32'(ov_val),   32'd1);
    check_val("ov_only_stale", 32'(ov_stale), 32'd0);
    check_val("ov_only_track", 32'(tr_ack),   32'd0);
    step(1);

    // Tracer only, held: ack every other cycle.
    tr_req = 1'b1; tr_col = 4'd7; tr_row = 4'd2;
    step(1);
    check_val("tr_only_ack1", 32'(tr_ack), 32'd1);
    check_val("tr_only_val",  32'(tr_val), 32'd0);
    step(1);
    check_val("tr_only_gap",  32'(tr_ack), 32'd0);
    step(1);
    check_val("tr_only_ack2", 32'(tr_ack), 32'd1);
    tr_req = 1'b0;
    step(2);

    // Contention: forced grant on cycle LIMIT, visible one cycle later.
    ov_req = 1'b1; ov_col = 4'd1; ov_row = 4'd1;
    tr_req = 1'b1; tr_col = 4'd6; tr_row = 4'd6;
    ack_latency(lat, held_ok);
    check_val("force_latency", 32'(lat), 32'(LIMIT + 1));
    check_val("force_stale_held", 32'(held_ok), 32'd1);
    ov_req = 1'b0; tr_req = 1'b0;
    step(3);

    // Starvation counter restarts when tr_req drops for a cycle.
    ov_req = 1'b1; tr_req = 1'b1;
    step(5);
    tr_req = 1'b0;
    step(1);
    tr_req = 1'b1;
    ack_latency(lat, held_ok);
    check_val("restart_latency", 32'(lat), 32'(LIMIT + 1));
    ov_req = 1'b0; tr_req = 1'b0;
    step(3);

    // Reset arriving right after a tracer grant suppresses its ack.
    tr_req = 1'b1; tr_col = 4'd9; tr_row = 4'd4;
    step(1);
    reset = 1'b1; tr_req = 1'b0;
    #1;
    check_val("rst_mid_ack_k1", 32'(tr_ack), 32'd0);
    check_val("rst_mid_val_k1", 32'(tr_val), 32'd0);
    step(1);
    reset = 1'b0;
    #1;
    check_val("rst_mid_ack_k2", 32'(tr_ack), 32'd0);
    check_val("rst_mid_val_k2", 32'(tr_val), 32'd0);
    step(1);

    // Full-map sweep, alternating requesters, idle cycle between.
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) begin
        ov_req = 1'b1; ov_col = 4'(i); ov_row = 4'(i >> 4);
        step(1);
        ov_req = 1'b0;
        step(1);
      end else begin
        tr_req = 1'b1; tr_col = 4'(i); tr_row = 4'(i >> 4);
        step(2);
        tr_req = 1'b0;
        step(1);
      end
    end

    // Random mix; tracer address held stable while requesting.
    for (int i = 0; i < 400; i++) begin
      ov_req = 1'($urandom_range(0, 1));
      ov_col = 4'($urandom); ov_row = 4'($urandom);
      if (tr_ack) tr_req = 1'b0;
      else if (!tr_req) begin
        tr_req = 1'($urandom_range(0, 1));
        tr_col = 4'($urandom); tr_row = 4'($urandom);
      end
      step(1);
    end
    ov_req = 1'b0; tr_req = 1'b0;
    step(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
